if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 64-bit RISC-V core. It drives the synchronous instruction memory, tracks the in-flight fetch and presents `if_id_instr` to the decode stage, where `imm_gen` and the register file consume it. It also closes the branch loop: it takes the B-type immediate from `imm_gen` and `branch_taken` from decode, forms the target, and redirects fetch with a one-bubble penalty.

---
 rtl/if_stage_pkg.sv | 9 +
 rtl/if_stage_if.sv | 14 +
 rtl/if_stage_pc_target_adder.sv | 8 +
 rtl/if_stage.sv | 42 ++++
 tb/tb_if_stage.sv | 101 ++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared core constants (PC width, opcodes, bubble NOP)
package if_stage_pkg;
  localparam int PC_W = 64;
  localparam logic [6:0] R_FORMAT = 7'b0110011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] SD = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [31:0] NOP_INSTR = 32'h00000033;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch bus (imem_addr/imem_rdata), decode controls (stall/branch_taken/branch_imm) and IF/ID outputs; master=if_stage, slave=environment
interface if_stage_if;
  import if_stage_pkg::*;
  logic [PC_W-1:0] imem_addr;
  logic [31:0] imem_rdata;
  logic stall;
  logic branch_taken;
  logic [PC_W-1:0] branch_imm;
  logic [PC_W-1:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic if_id_valid;
  modport master(output imem_addr, if_id_pc, if_id_instr, if_id_valid, input imem_rdata, stall, branch_taken, branch_imm);
  modport slave(input imem_addr, if_id_pc, if_id_instr, if_id_valid, output imem_rdata, stall, branch_taken, branch_imm);
endinterface

// File: rtl/if_stage_pc_target_adder.sv
// pc_target_adder: target = base + imm*2 (imm in halfwords), wraps mod 2^PC_W; ports base, imm in, target out
module pc_target_adder import if_stage_pkg::*; (
  input  logic [PC_W-1:0] base,
  input  logic [PC_W-1:0] imm,
  output logic [PC_W-1:0] target
);
  assign target = base + (imm << 1);
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch + IF/ID register with one-bubble branch redirect; ports clk, reset (sync active-high), bus (if_stage_if.master)
module if_stage import if_stage_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  if_stage_if.master bus
);
  logic [PC_W-1:0] pc_q, req_pc_q, target, id_pc_q;
  logic [31:0] id_instr_q;
  logic req_valid_q, id_valid_q, redirect;
  pc_target_adder u_tgt (.base(id_pc_q), .imm(bus.branch_imm), .target(target));
  assign redirect = bus.branch_taken & id_valid_q;
  assign bus.imem_addr = reset ? RESET_PC : redirect ? target : bus.stall ? req_pc_q : pc_q;
  assign bus.if_id_pc = id_pc_q;
  assign bus.if_id_instr = id_instr_q;
  assign bus.if_id_valid = id_valid_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_valid_q <= 1'b0;
      id_pc_q <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else if (redirect) begin
      pc_q <= target + PC_W'(4);
      req_pc_q <= target;
      req_valid_q <= 1'b1;
      id_pc_q <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q <= pc_q + PC_W'(4);
      req_pc_q <= pc_q;
      req_valid_q <= 1'b1;
      id_pc_q <= req_pc_q;
      id_instr_q <= bus.imem_rdata;
      id_valid_q <= req_valid_q;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with ROM[i]=i
module tb_if_stage;
  import if_stage_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  if_stage_if bus();
  if_stage dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) bus.imem_rdata <= 32'(bus.imem_addr >> 2);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_imm = '0;
    tick; tick;
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.if_id_valid); end
    checks++; if (bus.if_id_instr !== 32'h00000033) begin errors++; $display("FAIL reset_instr got %h want 00000033", bus.if_id_instr); end
    checks++; if (bus.if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.if_id_pc); end
    checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
  endtask
  task automatic test_free_run;
    reset = 1'b0; #1;
    checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL run_addr0 got %h want 0", bus.imem_addr); end
    tick;
    checks++; if (bus.imem_addr !== 64'h4) begin errors++; $display("FAIL run_addr4 got %h want 4", bus.imem_addr); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL run_early_valid got %0b want 0", bus.if_id_valid); end
    tick;
    checks++; if (bus.imem_addr !== 64'h8) begin errors++; $display("FAIL run_addr8 got %h want 8", bus.imem_addr); end
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h0, 32'h0, 1'b1}) begin errors++; $display("FAIL run_id0 got pc %h instr %h v %0b want 0 0 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
    tick;
    checks++; if (bus.imem_addr !== 64'hc) begin errors++; $display("FAIL run_addr12 got %h want c", bus.imem_addr); end
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h4, 32'h1, 1'b1}) begin errors++; $display("FAIL run_id4 got pc %h instr %h v %0b want 4 1 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
    tick;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h8, 32'h2, 1'b1}) begin errors++; $display("FAIL run_id8 got pc %h instr %h v %0b want 8 2 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
  endtask
  task automatic test_stall;
    bus.stall = 1'b1; #1;
    checks++; if (bus.imem_addr !== 64'hc) begin errors++; $display("FAIL stall_addr got %h want c", bus.imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.imem_addr} !== {64'h8, 32'h2, 1'b1, 64'hc}) begin errors++; $display("FAIL stall_hold%0d got pc %h instr %h v %0b addr %h want 8 2 1 c", i, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.imem_addr); end
    end
    bus.stall = 1'b0; #1;
    checks++; if (bus.imem_addr !== 64'h10) begin errors++; $display("FAIL release_addr got %h want 10", bus.imem_addr); end
    tick;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'hc, 32'h3, 1'b1}) begin errors++; $display("FAIL release_id12 got pc %h instr %h v %0b want c 3 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
    tick;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h10, 32'h4, 1'b1}) begin errors++; $display("FAIL release_id16 got pc %h instr %h v %0b want 10 4 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
  endtask
  task automatic wait_pc20;
    for (int i = 0; i < 16 && !(bus.if_id_pc === 64'h20 && bus.if_id_valid === 1'b1); i++) tick;
    checks++; if (bus.if_id_pc !== 64'h20 || bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL wait_pc20 got pc %h v %0b want 20 1", bus.if_id_pc, bus.if_id_valid); end
  endtask
  task automatic test_branch;
    wait_pc20;
    bus.branch_taken = 1'b1; bus.branch_imm = 64'hFFFF_FFFF_FFFF_FFF8; #1;
    checks++; if (bus.imem_addr !== 64'h10) begin errors++; $display("FAIL br_addr got %h want 10", bus.imem_addr); end
    tick;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h0, 32'h00000033, 1'b0}) begin errors++; $display("FAIL br_bubble got pc %h instr %h v %0b want 0 00000033 0", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
    checks++; if (bus.imem_addr !== 64'h14) begin errors++; $display("FAIL br_ignored_addr got %h want 14", bus.imem_addr); end
    tick;
    bus.branch_taken = 1'b0; #1;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h10, 32'h4, 1'b1}) begin errors++; $display("FAIL br_target got pc %h instr %h v %0b want 10 4 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
    checks++; if (bus.imem_addr !== 64'h18) begin errors++; $display("FAIL br_seq_addr got %h want 18", bus.imem_addr); end
  endtask
  task automatic test_branch_stall;
    wait_pc20;
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_imm = 64'hFFFF_FFFF_FFFF_FFF8; #1;
    checks++; if (bus.imem_addr !== 64'h10) begin errors++; $display("FAIL bs_addr got %h want 10", bus.imem_addr); end
    tick;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; #1;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.imem_addr} !== {64'h0, 32'h00000033, 1'b0, 64'h14}) begin errors++; $display("FAIL bs_bubble got pc %h instr %h v %0b addr %h want 0 00000033 0 14", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.imem_addr); end
    tick;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h10, 32'h4, 1'b1}) begin errors++; $display("FAIL bs_target got pc %h instr %h v %0b want 10 4 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
  endtask
  task automatic test_reset_mid;
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_imm = 64'hFFFF_FFFF_FFFF_FFF8; reset = 1'b1; #1;
    checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL rm_addr got %h want 0", bus.imem_addr); end
    tick;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h0, 32'h00000033, 1'b0}) begin errors++; $display("FAIL rm_id got pc %h instr %h v %0b want 0 00000033 0", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
    reset = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0; #1;
    checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL rm_restart_addr got %h want 0", bus.imem_addr); end
    tick;
    checks++; if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 64'h4) begin errors++; $display("FAIL rm_first got v %0b addr %h want 0 4", bus.if_id_valid, bus.imem_addr); end
    tick;
    checks++; if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_valid} !== {64'h0, 32'h0, 1'b1}) begin errors++; $display("FAIL rm_id0 got pc %h instr %h v %0b want 0 0 1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
  endtask
  initial begin
    test_reset;
    test_free_run;
    test_stall;
    test_branch;
    test_branch_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
